level_fifo: RTL and testbench



---
 rtl/level_fifo_pkg.sv | 16 +
 rtl/level_fifo_mem.sv | 52 +++++
 rtl/level_fifo.sv | 137 +++++++++++++
 tb/tb_level_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/level_fifo_pkg.sv
// level_fifo_pkg: helpers shared by level_fifo and future FIFO variants.
//   level_w - width of a level/threshold field able to hold 0..depth
//   ptr_inc - pointer increment with explicit wrap at depth-1 (non power-of-two safe)
package level_fifo_pkg;

    // Width of a level_t style field for a FIFO of the given depth.
    function automatic int unsigned level_w(input int unsigned depth);
        return 32'($clog2(depth + 1));
    endfunction

    // Increment a pointer, wrapping from depth-1 back to 0 by compare.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/level_fifo_mem.sv
// Memory: FIFO storage array with byte-masked write and a head/popped read port.
//   clk            - clock, rising edge (no reset: contents are don't-care until written)
//   write_en_in    - write strobe; write_addr_in/write_data_in/write_mask_in qualify it
//   read_en_in     - pop strobe; captures the addressed entry when SHOWAHEAD=0
//   read_addr_in   - entry presented on read_data_out
//   read_data_out  - SHOWAHEAD=1: entry at read_addr_in; SHOWAHEAD=0: last captured entry
module Memory
    import level_fifo_pkg::*;
#(
    parameter int unsigned WIDTH_BYTES = 4,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SHOWAHEAD   = 1,
    localparam int unsigned DW         = 8 * WIDTH_BYTES,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   write_en_in,
    input  logic [AW-1:0]          write_addr_in,
    input  logic [DW-1:0]          write_data_in,
    input  logic [WIDTH_BYTES-1:0] write_mask_in,
    input  logic                   read_en_in,
    input  logic [AW-1:0]          read_addr_in,
    output logic [DW-1:0]          read_data_out
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_q;
    logic [DW-1:0] w_head;

    // Byte-masked write.
    always_ff @(posedge clk) begin
        if (write_en_in) begin
            for (int b = 0; b < int'(WIDTH_BYTES); b++) begin
                if (write_mask_in[b]) begin
                    r_mem[write_addr_in][b*8 +: 8] <= write_data_in[b*8 +: 8];
                end
            end
        end
    end

    assign w_head = r_mem[read_addr_in];

    // Popped-entry capture; a same-edge write to the same slot returns the old entry.
    always_ff @(posedge clk) begin
        if (read_en_in) begin
            r_rd_q <= w_head;
        end
    end

    assign read_data_out = (SHOWAHEAD != 0) ? w_head : r_rd_q;

endmodule

// File: rtl/level_fifo.sv
// level_fifo: single-clock FIFO of any depth >= 2 with occupancy counter,
// programmable almost-full/almost-empty flags and sticky overflow/underflow.
//   clk, reset                 - clock and asynchronous active-high reset
//   write_in/write_data_in     - push request and data
//   read_in/read_data_out      - pop request and head (SHOWAHEAD=1) or popped data
//   clear_in                   - synchronous flush of pointers and level
//   afull/aempty_thresh_in     - thresholds compared against the next level
//   err_clear_in               - clears sticky flags (and restarts peak tracking)
//   level_out, empty/full_out, afull/aempty_out, overflow/underflow_out - registered status
//   max_level_out              - peak level; only when LEVEL_FIFO_STATS_EN is defined, else 0
//   debugen_in                 - per-cycle trace print (simulation only)
module level_fifo
    import level_fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH_BYTES = 4,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned SHOWAHEAD        = 1,
    localparam int unsigned LW              = level_w(FIFO_DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          write_in,
    input  logic [8*FIFO_WIDTH_BYTES-1:0] write_data_in,
    input  logic                          read_in,
    output logic [8*FIFO_WIDTH_BYTES-1:0] read_data_out,
    input  logic                          clear_in,
    input  logic [LW-1:0]                 afull_thresh_in,
    input  logic [LW-1:0]                 aempty_thresh_in,
    input  logic                          err_clear_in,
    output logic [LW-1:0]                 level_out,
    output logic                          empty_out,
    output logic                          full_out,
    output logic                          afull_out,
    output logic                          aempty_out,
    output logic                          overflow_out,
    output logic                          underflow_out,
    output logic [LW-1:0]                 max_level_out,
    input  logic                          debugen_in
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [PW-1:0]               r_wp, r_rp;
    logic [PW-1:0]               w_wp_nxt, w_rp_nxt;
    logic [LW-1:0]               w_level_nxt;
    logic                        w_push, w_pop, w_ovf_evt, w_unf_evt;
    logic [FIFO_WIDTH_BYTES-1:0] w_mask;

    // Accept/reject decisions; a pop frees the slot a same-cycle push needs when full.
    assign w_push    = write_in && (!full_out || read_in) && !clear_in;
    assign w_pop     = read_in && !empty_out && !clear_in;
    assign w_ovf_evt = write_in && !w_push && !clear_in;
    assign w_unf_evt = read_in && empty_out && !clear_in;
    assign w_mask    = '1;

    // Next pointers and level.
    always_comb begin
        w_wp_nxt    = r_wp;
        w_rp_nxt    = r_rp;
        w_level_nxt = level_out;
        if (clear_in) begin
            w_wp_nxt    = '0;
            w_rp_nxt    = '0;
            w_level_nxt = '0;
        end else begin
            if (w_push) w_wp_nxt = PW'(ptr_inc(32'(r_wp), FIFO_DEPTH));
            if (w_pop)  w_rp_nxt = PW'(ptr_inc(32'(r_rp), FIFO_DEPTH));
            w_level_nxt = level_out + LW'(w_push) - LW'(w_pop);
        end
    end

    // Pointer, level and flag registers; flags derive from the next level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp          <= '0;
            r_rp          <= '0;
            level_out     <= '0;
            empty_out     <= 1'b1;
            full_out      <= 1'b0;
            afull_out     <= 1'b0;
            aempty_out    <= 1'b1;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else begin
            r_wp          <= w_wp_nxt;
            r_rp          <= w_rp_nxt;
            level_out     <= w_level_nxt;
            empty_out     <= (w_level_nxt == '0);
            full_out      <= (w_level_nxt == LW'(FIFO_DEPTH));
            afull_out     <= (w_level_nxt >= afull_thresh_in);
            aempty_out    <= (w_level_nxt <= aempty_thresh_in);
            // A new error in the same cycle as err_clear_in keeps the flag set.
            overflow_out  <= w_ovf_evt || (overflow_out && !err_clear_in);
            underflow_out <= w_unf_evt || (underflow_out && !err_clear_in);
        end
    end

`ifdef LEVEL_FIFO_STATS_EN
    // Peak occupancy; err_clear_in restarts tracking from the current level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_level_out <= '0;
        end else if (err_clear_in || (w_level_nxt > max_level_out)) begin
            max_level_out <= w_level_nxt;
        end
    end
`else
    assign max_level_out = '0;
`endif

    Memory #(
        .WIDTH_BYTES (FIFO_WIDTH_BYTES),
        .DEPTH       (FIFO_DEPTH),
        .SHOWAHEAD   (SHOWAHEAD)
    ) mem (
        .clk           (clk),
        .write_en_in   (w_push),
        .write_addr_in (r_wp),
        .write_data_in (write_data_in),
        .write_mask_in (w_mask),
        .read_en_in    (w_pop),
        .read_addr_in  (r_rp),
        .read_data_out (read_data_out)
    );

`ifndef SYNTHESIS
    // Per-cycle trace.
    always_ff @(posedge clk) begin
        if (debugen_in) begin
            $display("%m: wr=%0b rd=%0b clr=%0b push=%0b pop=%0b wp=%0d rp=%0d level=%0d e=%0b f=%0b af=%0b ae=%0b ovf=%0b unf=%0b",
                     write_in, read_in, clear_in, w_push, w_pop, r_wp, r_rp, level_out,
                     empty_out, full_out, afull_out, aempty_out, overflow_out, underflow_out);
        end
    end
`endif

endmodule

// File: tb/tb_level_fifo.sv
// Bench for level_fifo: DEPTH=5 instances with SHOWAHEAD=1 and SHOWAHEAD=0 share
// stimulus and are compared each cycle against a queue-based reference model.
module tb_level_fifo;

    localparam int unsigned WB = 2;
    localparam int unsigned D  = 5;
    localparam int unsigned DW = 8 * WB;
    localparam int unsigned LW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          write_in, read_in, clear_in, err_clear_in, debugen_in;
    logic [DW-1:0] write_data_in;
    logic [LW-1:0] afull_thresh_in, aempty_thresh_in;

    logic [DW-1:0] rd1, rd0;
    logic [LW-1:0] lvl1, lvl0, mx1, mx0;
    logic          e1, f1, af1, ae1, ov1, un1;
    logic          e0, f0, af0, ae0, ov0, un0;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_last;
    bit            m_last_v, m_ovf, m_unf, m_af, m_ae;
    int            m_max;
    logic [DW-1:0] first_pushed;

    always #5 clk = ~clk;

    level_fifo #(.FIFO_WIDTH_BYTES(WB), .FIFO_DEPTH(D), .SHOWAHEAD(1)) u_sa1 (
        .clk(clk), .reset(reset), .write_in(write_in), .write_data_in(write_data_in),
        .read_in(read_in), .read_data_out(rd1), .clear_in(clear_in),
        .afull_thresh_in(afull_thresh_in), .aempty_thresh_in(aempty_thresh_in),
        .err_clear_in(err_clear_in), .level_out(lvl1), .empty_out(e1), .full_out(f1),
        .afull_out(af1), .aempty_out(ae1), .overflow_out(ov1), .underflow_out(un1),
        .max_level_out(mx1), .debugen_in(debugen_in));

    level_fifo #(.FIFO_WIDTH_BYTES(WB), .FIFO_DEPTH(D), .SHOWAHEAD(0)) u_sa0 (
        .clk(clk), .reset(reset), .write_in(write_in), .write_data_in(write_data_in),
        .read_in(read_in), .read_data_out(rd0), .clear_in(clear_in),
        .afull_thresh_in(afull_thresh_in), .aempty_thresh_in(aempty_thresh_in),
        .err_clear_in(err_clear_in), .level_out(lvl0), .empty_out(e0), .full_out(f0),
        .afull_out(af0), .aempty_out(ae0), .overflow_out(ov0), .underflow_out(un0),
        .max_level_out(mx0), .debugen_in(debugen_in));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last_v = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        m_af     = 1'b0;
        m_ae     = 1'b1;
        m_max    = 0;
    endtask

    // Apply the FIFO rules to the inputs present at this clock edge.
    task automatic model_edge();
        int sz;
        bit pop_ok, push_ok, ovf_e, unf_e;
        sz    = m_q.size();
        ovf_e = 1'b0;
        unf_e = 1'b0;
        if (clear_in) begin
            m_q.delete();
        end else begin
            pop_ok  = read_in && (sz > 0);
            push_ok = write_in && ((sz < int'(D)) || read_in);
            ovf_e   = write_in && !push_ok;
            unf_e   = read_in && (sz == 0);
            if (pop_ok) begin
                m_last   = m_q.pop_front();
                m_last_v = 1'b1;
            end
            if (push_ok) m_q.push_back(write_data_in);
        end
        m_ovf = ovf_e || (m_ovf && !err_clear_in);
        m_unf = unf_e || (m_unf && !err_clear_in);
        m_af  = m_q.size() >= int'(afull_thresh_in);
        m_ae  = m_q.size() <= int'(aempty_thresh_in);
        if (err_clear_in || (m_q.size() > m_max)) m_max = m_q.size();
    endtask

    task automatic check_one(input string p, input logic [LW-1:0] lvl, input logic e,
                             input logic f, input logic af, input logic ae, input logic ov,
                             input logic un, input logic [LW-1:0] mx);
        int exp_max;
`ifdef LEVEL_FIFO_STATS_EN
        exp_max = m_max;
`else
        exp_max = 0;
`endif
        chk({p, "_level"},  32'(lvl), 32'(m_q.size()));
        chk({p, "_empty"},  32'(e),   32'(m_q.size() == 0));
        chk({p, "_full"},   32'(f),   32'(m_q.size() == int'(D)));
        chk({p, "_afull"},  32'(af),  32'(m_af));
        chk({p, "_aempty"}, 32'(ae),  32'(m_ae));
        chk({p, "_ovf"},    32'(ov),  32'(m_ovf));
        chk({p, "_unf"},    32'(un),  32'(m_unf));
        chk({p, "_max"},    32'(mx),  32'(exp_max));
    endtask

    task automatic check_all();
        check_one("sa1", lvl1, e1, f1, af1, ae1, ov1, un1, mx1);
        check_one("sa0", lvl0, e0, f0, af0, ae0, ov0, un0, mx0);
        if (m_q.size() > 0) chk("sa1_head", 32'(rd1), 32'(m_q[0]));
        if (m_last_v)       chk("sa0_popped", 32'(rd0), 32'(m_last));
    endtask

    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c, input bit ec);
        write_in      = w;
        write_data_in = d;
        read_in       = r;
        clear_in      = c;
        err_clear_in  = ec;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Asynchronous reset between edges; outputs must be back at reset values at once.
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        write_in         = 1'b0;
        read_in          = 1'b0;
        clear_in         = 1'b0;
        err_clear_in     = 1'b0;
        debugen_in       = 1'b0;
        write_data_in    = '0;
        afull_thresh_in  = 3'd4;
        aempty_thresh_in = 3'd1;
        #3;
        model_reset();
        check_all();
        #4;
        reset = 1'b0;
        @(negedge clk);

        // Fill to full.
        first_pushed = DW'($urandom);
        step(1, first_pushed, 0, 0, 0);
        chk("aempty_at1", 32'(ae1), 32'd1);
        step(1, DW'($urandom), 0, 0, 0);
        chk("aempty_at2", 32'(ae1), 32'd0);
        step(1, DW'($urandom), 0, 0, 0);
        step(1, DW'($urandom), 0, 0, 0);
        chk("afull_at4", 32'(af1), 32'd1);
        step(1, DW'($urandom), 0, 0, 0);
        chk("full_at5", 32'(f1), 32'd1);
        chk("level_5", 32'(lvl0), 32'd5);

        // Overflow, then simultaneous push/pop while full.
        step(1, 16'h00AA, 0, 0, 0);
        chk("ovf_set", 32'(ov0), 32'd1);
        chk("level_hold", 32'(lvl1), 32'd5);
        step(1, DW'($urandom), 1, 0, 0);
        chk("level_pushpop_full", 32'(lvl1), 32'd5);
        chk("oldest_out", 32'(rd0), 32'(first_pushed));

        // Drain, underflow, push/pop while empty, error clear.
        for (int i = 0; i < 5; i++) step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        chk("unf_set", 32'(un1), 32'd1);
        step(1, 16'h5A5A, 1, 0, 0);
        chk("level_pushpop_empty", 32'(lvl1), 32'd1);
        step(0, '0, 0, 0, 1);
        chk("flags_cleared", 32'({ov1, un1}), 32'd0);
        step(0, '0, 1, 0, 0);

        // Ordering and data latency of both read modes.
        step(1, 16'h0011, 0, 0, 0);
        step(1, 16'h0022, 0, 0, 0);
        step(1, 16'h0033, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0);
        chk("sa0_last", 32'(rd0), 32'h33);

        // Clear with a simultaneous push at level 3.
        for (int i = 0; i < 3; i++) step(1, DW'($urandom), 0, 0, 0);
        step(1, DW'($urandom), 0, 1, 0);
        chk("clear_empty", 32'(e1), 32'd1);

        // Reset mid-burst at level 2.
        step(1, DW'($urandom), 0, 0, 0);
        step(1, DW'($urandom), 0, 0, 0);
        pulse_reset();
        @(negedge clk);

        // Randomised traffic with moving thresholds, clears, error clears and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                afull_thresh_in  = LW'($urandom_range(0, 7));
                aempty_thresh_in = LW'($urandom_range(0, 7));
            end
            step(1'($urandom), DW'($urandom), 1'($urandom), $urandom_range(0, 24) == 0,
                 $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
